// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - register map, bit positions and CTRL layout shared by the UART receive path
package uart_pkg;

  localparam logic [1:0] RX_DATA   = 2'd0;
  localparam logic [1:0] RX_STATUS = 2'd1;
  localparam logic [1:0] RX_CTRL   = 2'd2;
  localparam logic [1:0] RX_FLUSH  = 2'd3;

  localparam int STAT_OVF   = 7;
  localparam int STAT_FULL  = 6;
  localparam int STAT_EMPTY = 5;

  localparam int CTRL_RX_IE  = 7;
  localparam int CTRL_OVF_IE = 6;
  localparam int CTRL_RSVD   = 5;

  localparam logic [7:0] CTRL_RESET = 8'h01;

  typedef struct packed {
    logic       rx_ie;
    logic       ovf_ie;
    logic       rsvd;
    logic [4:0] thresh;
  } rx_ctrl_t;

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - circular byte FIFO with flush and a dropped-push flag
module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [7:0]               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A pop frees the slot the same-cycle push needs, so a full FIFO still accepts it.
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~flush & (~full | do_pop);
  assign dropped = push & ~flush & full & ~do_pop;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receive buffer with CPU register interface and level/overflow interrupt
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  input  logic       cs,
  input  logic       rwb,
  input  logic [1:0] addr,
  input  logic [7:0] i_data,
  output logic [7:0] o_data,
  output logic       irqb
);

  logic          rd_acc;
  logic          wr_acc;
  logic          pop;
  logic          flush;
  logic          status_wr;
  logic          ctrl_wr;
  logic [7:0]    head;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [4:0]    count5;
  logic          dropped;
  logic          overflow;
  rx_ctrl_t      ctrl_q;
  logic [7:0]    status;
  logic          level_hit;

  assign rd_acc    = cs & rwb;
  assign wr_acc    = cs & ~rwb;
  assign pop       = rd_acc & (addr == RX_DATA);
  assign flush     = wr_acc & (addr == RX_FLUSH);
  assign status_wr = wr_acc & (addr == RX_STATUS);
  assign ctrl_wr   = wr_acc & (addr == RX_CTRL);

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (i_rx_valid),
    .push_data (i_rx_data),
    .pop       (pop),
    .flush     (flush),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .dropped   (dropped)
  );

  assign count5 = 5'(count);

  // A drop in the same cycle as a clear leaves overflow set so the loss is never hidden.
  always_ff @(posedge clk) begin
    if (reset || flush)
      overflow <= 1'b0;
    else if (dropped)
      overflow <= 1'b1;
    else if (status_wr && i_data[STAT_OVF])
      overflow <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset)
      ctrl_q <= rx_ctrl_t'(CTRL_RESET);
    else if (ctrl_wr)
      ctrl_q <= rx_ctrl_t'(i_data & ~(8'h01 << CTRL_RSVD));
  end

  assign level_hit = ctrl_q.rx_ie & (count5 >= ctrl_q.thresh) & (ctrl_q.thresh != 5'd0);

  always_ff @(posedge clk) begin
    if (reset)
      irqb <= 1'b1;
    else
      irqb <= ~(level_hit | (ctrl_q.ovf_ie & overflow));
  end

  always_comb begin
    status             = '0;
    status[STAT_OVF]   = overflow;
    status[STAT_FULL]  = full;
    status[STAT_EMPTY] = empty;
    status[4:0]        = count5;
  end

  always_comb begin
    o_data = 8'h00;
    case (addr)
      RX_DATA:   o_data = empty ? 8'h00 : head;
      RX_STATUS: o_data = status;
      RX_CTRL:   o_data = ctrl_q;
      default:   o_data = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed table and sequence checks for uart_rx_fifo
module tb_uart_rx_fifo;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] i_rx_data;
  logic       i_rx_valid;
  logic       cs;
  logic       rwb;
  logic [1:0] addr;
  logic [7:0] i_data;
  logic [7:0] o_data;
  logic       irqb;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_rx_data  (i_rx_data),
    .i_rx_valid (i_rx_valid),
    .cs         (cs),
    .rwb        (rwb),
    .addr       (addr),
    .i_data     (i_data),
    .o_data     (o_data),
    .irqb       (irqb)
  );

  typedef struct {
    logic       cs;
    logic       rwb;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic       rxv;
    logic [7:0] rxd;
    logic       chk;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic drive(input logic c, input logic r, input logic [1:0] a,
                       input logic [7:0] w, input logic v, input logic [7:0] d);
    @(negedge clk);
    cs = c; rwb = r; addr = a; i_data = w; i_rx_valid = v; i_rx_data = d;
    #1;
  endtask

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h, expected %02h", nm, act, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] exp, input string nm);
    drive(1'b1, 1'b1, a, 8'h00, 1'b0, 8'h00);
    check(nm, o_data, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    drive(1'b1, 1'b0, a, d, 1'b0, 8'h00);
  endtask

  task automatic push(input logic [7:0] d);
    drive(1'b0, 1'b1, 2'd0, 8'h00, 1'b1, d);
  endtask

  task automatic idle();
    drive(1'b0, 1'b1, 2'd0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic check_irq(input string nm, input logic exp);
    idle();
    idle();
    check(nm, {7'd0, irqb}, {7'd0, exp});
  endtask

  initial begin
    reset = 1'b1;
    cs = 1'b0; rwb = 1'b1; addr = 2'd0; i_data = 8'h00;
    i_rx_valid = 1'b1; i_rx_data = 8'h55;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    i_rx_valid = 1'b0;
    #1;
    check("reset_irqb", {7'd0, irqb}, 8'h01);

    //                cs    rwb   addr       wdata  rxv   rxd    chk   exp
    tbl.push_back('{1'b1, 1'b1, RX_STATUS, 8'h00, 1'b0, 8'h00, 1'b1, 8'h20});
    tbl.push_back('{1'b1, 1'b1, RX_CTRL,   8'h00, 1'b0, 8'h00, 1'b1, 8'h01});
    tbl.push_back('{1'b1, 1'b1, RX_DATA,   8'h00, 1'b0, 8'h00, 1'b1, 8'h00});
    tbl.push_back('{1'b0, 1'b1, RX_DATA,   8'h00, 1'b1, 8'h41, 1'b0, 8'h00});
    tbl.push_back('{1'b0, 1'b1, RX_DATA,   8'h00, 1'b1, 8'h42, 1'b0, 8'h00});
    tbl.push_back('{1'b0, 1'b1, RX_DATA,   8'h00, 1'b1, 8'h43, 1'b0, 8'h00});
    tbl.push_back('{1'b1, 1'b1, RX_STATUS, 8'h00, 1'b0, 8'h00, 1'b1, 8'h03});
    tbl.push_back('{1'b1, 1'b1, RX_DATA,   8'h00, 1'b0, 8'h00, 1'b1, 8'h41});
    tbl.push_back('{1'b1, 1'b1, RX_DATA,   8'h00, 1'b0, 8'h00, 1'b1, 8'h42});
    tbl.push_back('{1'b1, 1'b1, RX_DATA,   8'h00, 1'b0, 8'h00, 1'b1, 8'h43});
    tbl.push_back('{1'b1, 1'b1, RX_STATUS, 8'h00, 1'b0, 8'h00, 1'b1, 8'h20});
    tbl.push_back('{1'b1, 1'b1, RX_DATA,   8'h00, 1'b0, 8'h00, 1'b1, 8'h00});
    tbl.push_back('{1'b1, 1'b1, RX_STATUS, 8'h00, 1'b0, 8'h00, 1'b1, 8'h20});
    tbl.push_back('{1'b1, 1'b1, RX_DATA,   8'h00, 1'b1, 8'h99, 1'b1, 8'h00});
    tbl.push_back('{1'b1, 1'b1, RX_STATUS, 8'h00, 1'b0, 8'h00, 1'b1, 8'h01});
    tbl.push_back('{1'b1, 1'b0, RX_DATA,   8'h12, 1'b0, 8'h00, 1'b0, 8'h00});
    tbl.push_back('{1'b1, 1'b1, RX_DATA,   8'h00, 1'b0, 8'h00, 1'b1, 8'h99});
    tbl.push_back('{1'b1, 1'b0, RX_CTRL,   8'hFF, 1'b0, 8'h00, 1'b0, 8'h00});
    tbl.push_back('{1'b1, 1'b1, RX_CTRL,   8'h00, 1'b0, 8'h00, 1'b1, 8'hDF});
    tbl.push_back('{1'b1, 1'b0, RX_CTRL,   8'h01, 1'b0, 8'h00, 1'b0, 8'h00});
    tbl.push_back('{1'b1, 1'b1, RX_CTRL,   8'h00, 1'b0, 8'h00, 1'b1, 8'h01});
    tbl.push_back('{1'b1, 1'b1, RX_FLUSH,  8'h00, 1'b0, 8'h00, 1'b1, 8'h00});
    tbl.push_back('{1'b1, 1'b1, RX_STATUS, 8'h00, 1'b0, 8'h00, 1'b1, 8'h20});

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].cs, tbl[i].rwb, tbl[i].addr, tbl[i].wdata, tbl[i].rxv, tbl[i].rxd);
      if (tbl[i].chk) check($sformatf("vec%0d", i), o_data, tbl[i].exp);
    end
    idle();

    // Fill, then drop a byte while clearing overflow in the same cycle.
    for (int i = 0; i < 16; i++) push(8'(i));
    rd(RX_STATUS, 8'h50, "full_status");
    drive(1'b1, 1'b0, RX_STATUS, 8'h80, 1'b1, 8'h10);
    rd(RX_STATUS, 8'hD0, "ovf_set_wins");
    wr(RX_STATUS, 8'h80);
    rd(RX_STATUS, 8'h50, "ovf_cleared");
    drive(1'b1, 1'b1, RX_DATA, 8'h00, 1'b1, 8'hAA);
    check("full_push_pop_data", o_data, 8'h00);
    rd(RX_STATUS, 8'h50, "full_push_pop_status");
    for (int i = 1; i < 16; i++) rd(RX_DATA, 8'(i), $sformatf("drain%0d", i));
    rd(RX_DATA, 8'hAA, "drain_aa");
    rd(RX_STATUS, 8'h20, "drained_status");

    wr(RX_CTRL, 8'h84);
    push(8'h31); push(8'h32); push(8'h33);
    check_irq("irq_below_thresh", 1'b1);
    push(8'h34);
    check_irq("irq_at_thresh", 1'b0);
    rd(RX_DATA, 8'h31, "irq_pop_data");
    check_irq("irq_after_pop", 1'b1);

    wr(RX_CTRL, 8'h40);
    for (int i = 0; i < 14; i++) push(8'h60 + 8'(i));
    check_irq("irq_overflow", 1'b0);
    rd(RX_STATUS, 8'hD0, "ovf_status");
    wr(RX_STATUS, 8'h80);
    check_irq("irq_ovf_cleared", 1'b1);
    wr(RX_CTRL, 8'h80);
    check_irq("irq_thresh_zero", 1'b1);

    wr(RX_FLUSH, 8'h00);
    rd(RX_STATUS, 8'h20, "flush_status");
    wr(RX_CTRL, 8'hC4);
    for (int i = 0; i < 5; i++) push(8'h70 + 8'(i));
    check_irq("irq_five_held", 1'b0);
    rd(RX_STATUS, 8'h05, "five_status");
    drive(1'b1, 1'b0, RX_FLUSH, 8'h00, 1'b1, 8'h77);
    idle();
    rd(RX_STATUS, 8'h20, "flush_push_status");
    rd(RX_DATA, 8'h00, "flush_push_data");
    idle();
    check("flush_irqb", {7'd0, irqb}, 8'h01);

    // Mid-operation reset discards the same-cycle strobe and restores CTRL.
    push(8'h88);
    @(negedge clk);
    reset = 1'b1; i_rx_valid = 1'b1; i_rx_data = 8'h99;
    @(negedge clk);
    reset = 1'b0; i_rx_valid = 1'b0;
    rd(RX_STATUS, 8'h20, "midreset_status");
    rd(RX_CTRL, 8'h01, "midreset_ctrl");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
